// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_pkg                                                      |
// | Description : HD44780 command bytes, state encoding and lookup helpers     |
// |               used by the character-LCD frame driver.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lcd_pkg;

   localparam logic [7:0] FUNC_SET  = 8'h38;
   localparam logic [7:0] DISP_OFF  = 8'h08;
   localparam logic [7:0] CLEAR     = 8'h01;
   localparam logic [7:0] DISP_ON   = 8'h0C;
   localparam logic [7:0] ENTRY     = 8'h06;
   localparam logic [7:0] SET_DDRAM = 8'h80;
   localparam logic [7:0] BLANK     = 8'h20;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_WAIT = 2'd1,
      ST_ADDR = 2'd2,
      ST_CHAR = 2'd3
   } lcd_state_e;

   // DDRAM start address of each panel row (HD44780 4-line layout).
   function automatic logic [7:0] row_base(input logic [1:0] row);
      case (row)
         2'd0:    return 8'h00;
         2'd1:    return 8'h40;
         2'd2:    return 8'h14;
         default: return 8'h54;
      endcase
   endfunction

   // Command byte issued at each power-on init step.
   function automatic logic [7:0] init_cmd(input logic [2:0] step);
      case (step)
         3'd0, 3'd1, 3'd2, 3'd3: return FUNC_SET;
         3'd4:                   return DISP_OFF;
         3'd5:                   return CLEAR;
         3'd6:                   return DISP_ON;
         default:                return ENTRY;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_char_buffer                                              |
// | Description : DEPTH x 8 character register file, resets to blanks, one    |
// |               write port and one combinational read port.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_char_buffer
   import lcd_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [7:0]    rd_data_o
);

   logic [7:0] mem_q [DEPTH];

   // Cell storage: blank on reset, writes beyond the last cell are dropped.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= BLANK;
         end
      end else if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // The refresh FSM only ever addresses valid cells.
   assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/lcd_frame_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_frame_driver                                             |
// | Description : HD44780 driver: power-on init, then continuous refresh of a  |
// |               ROWS x COLS character buffer written by upstream logic.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lcd_frame_driver
   import lcd_pkg::*;
#(
   parameter int ROWS     = 2,
   parameter int COLS     = 16,
   parameter int CLR_WAIT = 0,
   parameter int AW       = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic          CLK_400Hz,
   input  logic          resetn,
   input  logic          hold,
   input  logic          reinit,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   output logic          init_done,
   output logic          frame_done,
   output logic          LCD_ON,
   output logic          LCD_RW,
   output logic          LCD_RS,
   output logic          LCD_EN,
   output logic [7:0]    LCD_DATA
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int WW = (CLR_WAIT > 0) ? $clog2(CLR_WAIT + 1) : 1;

   lcd_state_e    state_q, state_d;
   logic          phase_q, phase_d;        // 0 = phase H (EN high), 1 = phase L
   logic [2:0]    step_q, step_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          en_q, en_d;
   logic          rs_q, rs_d;
   logic [7:0]    data_q, data_d;
   logic          init_done_q, init_done_d;
   logic          frame_done_q, frame_done_d;
   logic          reinit_pend_q, reinit_pend_d;

   logic [AW-1:0] cell_addr;
   logic [7:0]    cell_data;
   logic          reinit_now;

   assign cell_addr  = AW'(int'(row_q) * COLS + int'(col_q));
   assign reinit_now = reinit_pend_q | reinit;

   lcd_char_buffer #(
      .DEPTH (ROWS * COLS),
      .AW    (AW)
   ) u_buf (
      .clk_i     (CLK_400Hz),
      .rst_ni    (resetn),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (cell_addr),
      .rd_data_o (cell_data)
   );

   // State, counters and all LCD-facing outputs are registered together.
   always_ff @(posedge CLK_400Hz or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_INIT;
         phase_q       <= 1'b0;
         step_q        <= 3'd0;
         row_q         <= '0;
         col_q         <= '0;
         wait_q        <= '0;
         en_q          <= 1'b0;
         rs_q          <= 1'b0;
         data_q        <= 8'h00;
         init_done_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         reinit_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         step_q        <= step_d;
         row_q         <= row_d;
         col_q         <= col_d;
         wait_q        <= wait_d;
         en_q          <= en_d;
         rs_q          <= rs_d;
         data_q        <= data_d;
         init_done_q   <= init_done_d;
         frame_done_q  <= frame_done_d;
         reinit_pend_q <= reinit_pend_d;
      end
   end

   // Sequencing: H drives a new byte, L drops EN and advances; reinit only acts at L.
   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      step_d        = step_q;
      row_d         = row_q;
      col_d         = col_q;
      wait_d        = wait_q;
      en_d          = en_q;
      rs_d          = rs_q;
      data_d        = data_q;
      init_done_d   = init_done_q;
      frame_done_d  = 1'b0;
      reinit_pend_d = reinit_pend_q | reinit;

      if (!hold) begin
         if (state_q == ST_WAIT) begin
            en_d = 1'b0;
            if (int'(wait_q) == CLR_WAIT - 1) begin
               state_d = ST_INIT;
               step_d  = 3'd6;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
            if (reinit_now) begin
               state_d       = ST_INIT;
               step_d        = 3'd0;
               wait_d        = '0;
               init_done_d   = 1'b0;
               reinit_pend_d = 1'b0;
            end
         end else if (!phase_q) begin
            en_d    = 1'b1;
            phase_d = 1'b1;
            case (state_q)
               ST_INIT: begin
                  rs_d   = 1'b0;
                  data_d = init_cmd(step_q);
               end
               ST_ADDR: begin
                  rs_d   = 1'b0;
                  data_d = SET_DDRAM | row_base(2'(row_q));
               end
               default: begin
                  rs_d   = 1'b1;
                  data_d = cell_data;
               end
            endcase
         end else begin
            en_d    = 1'b0;
            phase_d = 1'b0;
            case (state_q)
               ST_INIT: begin
                  if (step_q == 3'd5 && CLR_WAIT != 0) begin
                     state_d = ST_WAIT;
                     wait_d  = '0;
                  end else if (step_q == 3'd7) begin
                     state_d     = ST_ADDR;
                     row_d       = '0;
                     init_done_d = 1'b1;
                  end else begin
                     step_d = step_q + 3'd1;
                  end
               end
               ST_ADDR: begin
                  state_d = ST_CHAR;
                  col_d   = '0;
               end
               default: begin
                  if (int'(col_q) == COLS - 1) begin
                     col_d   = '0;
                     state_d = ST_ADDR;
                     if (int'(row_q) == ROWS - 1) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end
            endcase
            if (reinit_now) begin
               state_d       = ST_INIT;
               step_d        = 3'd0;
               init_done_d   = 1'b0;
               reinit_pend_d = 1'b0;
            end
         end
      end
   end

   assign LCD_ON     = 1'b1;
   assign LCD_RW     = 1'b0;
   assign LCD_RS     = rs_q;
   assign LCD_EN     = en_q;
   assign LCD_DATA   = data_q;
   assign init_done  = init_done_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lcd_frame_driver                                          |
// | Description : Directed self-checking bench for lcd_frame_driver, default   |
// |               2x16 instance plus a 4x20 instance with a clear wait.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lcd_frame_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-parameter instance
   logic       resetn, hold, reinit, wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       init_done, frame_done, lcd_on, lcd_rw, lcd_rs, lcd_en;
   logic [7:0] lcd_data;

   // 4x20 instance with CLR_WAIT=3
   logic       resetn2, hold2, reinit2, wr_en2;
   logic [6:0] wr_addr2;
   logic [7:0] wr_data2;
   logic       init_done2, frame_done2, lcd_on2, lcd_rw2, lcd_rs2, lcd_en2;
   logic [7:0] lcd_data2;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] model_buf [32];
   logic [7:0] init_seq  [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h0C, 8'h06};
   string      msg = "Patient:3";

   lcd_frame_driver dut (
      .CLK_400Hz (clk),      .resetn   (resetn),   .hold       (hold),
      .reinit    (reinit),   .wr_en    (wr_en),    .wr_addr    (wr_addr),
      .wr_data   (wr_data),  .init_done(init_done),.frame_done (frame_done),
      .LCD_ON    (lcd_on),   .LCD_RW   (lcd_rw),   .LCD_RS     (lcd_rs),
      .LCD_EN    (lcd_en),   .LCD_DATA (lcd_data)
   );

   lcd_frame_driver #(.ROWS(4), .COLS(20), .CLR_WAIT(3)) dut2 (
      .CLK_400Hz (clk),      .resetn   (resetn2),   .hold       (hold2),
      .reinit    (reinit2),  .wr_en    (wr_en2),    .wr_addr    (wr_addr2),
      .wr_data   (wr_data2), .init_done(init_done2),.frame_done (frame_done2),
      .LCD_ON    (lcd_on2),  .LCD_RW   (lcd_rw2),   .LCD_RS     (lcd_rs2),
      .LCD_EN    (lcd_en2),  .LCD_DATA (lcd_data2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 16-cycle init on the default instance; optionally loads "Patient:3" and cell 31 meanwhile.
   task automatic check_init(input bit do_write);
      for (int t = 0; t < 16; t++) begin
         if (do_write && t < 10) begin
            wr_en   = 1'b1;
            wr_addr = (t < 9) ? 5'(t) : 5'd31;
            wr_data = (t < 9) ? msg[t] : 8'h5A;
            model_buf[wr_addr] = wr_data;
         end else begin
            wr_en = 1'b0;
         end
         tick();
         chk1("init_en",   lcd_en,   (t % 2) == 0);
         chk1("init_rs",   lcd_rs,   1'b0);
         chk8("init_data", lcd_data, init_seq[t / 2]);
         chk1("init_done", init_done, t == 15);
      end
      wr_en = 1'b0;
   endtask

   // One byte transfer of the default frame, byte index 0..33.
   task automatic check_byte(input int b, input bit last);
      int         row, k;
      logic       exp_rs;
      logic [7:0] exp_d;
      row = b / 17;
      k   = b % 17;
      if (k == 0) begin
         exp_rs = 1'b0;
         exp_d  = (row == 1) ? 8'hC0 : 8'h80;
      end else begin
         exp_rs = 1'b1;
         exp_d  = model_buf[row * 16 + k - 1];
      end
      tick();
      chk1("byte_en_h",   lcd_en,     1'b1);
      chk1("byte_rs_h",   lcd_rs,     exp_rs);
      chk8("byte_data_h", lcd_data,   exp_d);
      chk1("fdone_h",     frame_done, 1'b0);
      tick();
      chk1("byte_en_l",   lcd_en,     1'b0);
      chk1("byte_rs_l",   lcd_rs,     exp_rs);
      chk8("byte_data_l", lcd_data,   exp_d);
      chk1("fdone_l",     frame_done, last);
   endtask

   task automatic check_frame();
      for (int b = 0; b < 34; b++) begin
         check_byte(b, b == 33);
      end
   endtask

   initial begin
      logic [7:0] exp_d2;
      resetn  = 1'b0; hold  = 1'b0; reinit  = 1'b0; wr_en  = 1'b0; wr_addr  = '0; wr_data  = '0;
      resetn2 = 1'b0; hold2 = 1'b0; reinit2 = 1'b0; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
      repeat (3) tick();

      // Reset state
      chk1("rst_en",    lcd_en,     1'b0);
      chk1("rst_rs",    lcd_rs,     1'b0);
      chk8("rst_data",  lcd_data,   8'h00);
      chk1("rst_idone", init_done,  1'b0);
      chk1("rst_fdone", frame_done, 1'b0);
      chk1("lcd_on",    lcd_on,     1'b1);
      chk1("lcd_rw",    lcd_rw,     1'b0);

      // Init sequence with buffer loading, then a full frame
      resetn = 1'b1;
      check_init(1'b1);
      check_frame();

      // Frame 2: hold for 10 cycles while 'P' is in phase H
      check_byte(0, 1'b0);
      tick();
      chk1("pre_hold_en", lcd_en, 1'b1);
      chk8("pre_hold_d",  lcd_data, 8'h50);
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk1("hold_en",    lcd_en,     1'b1);
         chk1("hold_rs",    lcd_rs,     1'b1);
         chk8("hold_data",  lcd_data,   8'h50);
         chk1("hold_fdone", frame_done, 1'b0);
      end
      hold = 1'b0;
      tick();
      chk1("post_hold_en", lcd_en,   1'b0);
      chk8("post_hold_d",  lcd_data, 8'h50);
      for (int b = 2; b < 34; b++) begin
         check_byte(b, b == 33);
      end

      // Frame 3: reinit pulse during a CHAR phase H
      check_byte(0, 1'b0);
      tick();
      chk1("pre_reinit_en", lcd_en, 1'b1);
      reinit = 1'b1;
      tick();
      reinit = 1'b0;
      chk1("reinit_l_en",    lcd_en,    1'b0);
      chk8("reinit_l_data",  lcd_data,  8'h50);
      chk1("reinit_idone",   init_done, 1'b0);
      check_init(1'b0);
      check_frame();

      // Async reset mid-frame: outputs clear immediately, buffer back to blanks
      check_byte(0, 1'b0);
      tick();
      chk1("pre_rst_en", lcd_en, 1'b1);
      resetn = 1'b0;
      #1;
      chk1("arst_en",    lcd_en,    1'b0);
      chk1("arst_rs",    lcd_rs,    1'b0);
      chk8("arst_data",  lcd_data,  8'h00);
      chk1("arst_idone", init_done, 1'b0);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
      check_init(1'b0);
      check_frame();

      // 4x20 instance: clear wait, 19-cycle init, row addresses, out-of-range writes
      resetn2 = 1'b1;
      for (int t = 0; t < 19; t++) begin
         wr_en2 = (t < 3);
         case (t)
            0:       begin wr_addr2 = 7'd80;  wr_data2 = 8'h58; end
            1:       begin wr_addr2 = 7'd127; wr_data2 = 8'h59; end
            default: begin wr_addr2 = 7'd79;  wr_data2 = 8'h5A; end
         endcase
         tick();
         if (t < 12) begin
            chk1("i2_en",   lcd_en2,   (t % 2) == 0);
            chk8("i2_data", lcd_data2, init_seq[t / 2]);
         end else if (t < 15) begin
            chk1("i2_wait_en",   lcd_en2,   1'b0);
            chk8("i2_wait_data", lcd_data2, 8'h01);
         end else begin
            chk1("i2_en",   lcd_en2,   ((t - 15) % 2) == 0);
            chk8("i2_data", lcd_data2, init_seq[6 + (t - 15) / 2]);
         end
         chk1("i2_done", init_done2, t == 18);
      end
      wr_en2 = 1'b0;
      for (int r = 0; r < 4; r++) begin
         case (r)
            0:       exp_d2 = 8'h80;
            1:       exp_d2 = 8'hC0;
            2:       exp_d2 = 8'h94;
            default: exp_d2 = 8'hD4;
         endcase
         tick();
         chk1("f2_addr_en", lcd_en2,   1'b1);
         chk1("f2_addr_rs", lcd_rs2,   1'b0);
         chk8("f2_addr",    lcd_data2, exp_d2);
         tick();
         chk1("f2_addr_en_l", lcd_en2, 1'b0);
         for (int c = 0; c < 20; c++) begin
            exp_d2 = (r == 3 && c == 19) ? 8'h5A : 8'h20;
            tick();
            chk1("f2_char_en", lcd_en2,   1'b1);
            chk1("f2_char_rs", lcd_rs2,   1'b1);
            chk8("f2_char",    lcd_data2, exp_d2);
            tick();
            chk1("f2_fdone",   frame_done2, r == 3 && c == 19);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
